// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states and
// the per-stage control bundle with its canonical decode patterns.
package pipeline_stall_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    typedef enum logic [1:0] {
        S_RUN      = ST_RUN,
        S_MEM_WAIT = ST_MEM_WAIT,
        S_HALT     = ST_HALT
    } state_e;

    typedef struct packed {
        logic pc_wr;
        logic ifid_wr;
        logic idex_wr;
        logic exmem_wr;
        logic memwb_wr;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE   = 8'b0000_0000;
    localparam ctrl_t CTRL_RUN    = 8'b1111_1000;
    localparam ctrl_t CTRL_FLUSH  = 8'b1111_1100;
    localparam ctrl_t CTRL_HAZARD = 8'b0011_1010;
    // Freeze: only Mem/Wb advances, taking a bubble while Mem is blocked.
    localparam ctrl_t CTRL_FREEZE = 8'b0000_1001;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next-count decode: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges hazard stalls, ID redirects and the
// multi-cycle data-memory handshake into per-stage enables, bubbles and flush.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             branch_taken_ID,
    input  logic             jump_ID,
    input  logic             mem_req_Mem,
    input  logic             mem_ack,
    output logic             PC_Wr,
    output logic             IFID_Wr,
    output logic             IDEx_Wr,
    output logic             ExMem_Wr,
    output logic             MemWb_Wr,
    output logic             IFID_flush,
    output logic             IDEx_bubble,
    output logic             MemWb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // The counter already holds the prior freeze cycles, so this is the last one.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q;
    state_e           state_d;
    logic             mem_err_q;
    logic             err_set_s;
    logic             wait_inc_s;
    logic             wait_clr_s;
    logic [CNT_W-1:0] wait_cnt_s;
    ctrl_t            ctrl_s;

    // Next-state and control decode from state and same-cycle requests.
    always_comb begin
        state_d    = state_q;
        ctrl_s     = CTRL_NONE;
        wait_inc_s = 1'b0;
        wait_clr_s = 1'b0;
        err_set_s  = 1'b0;
        if (rst) begin
            state_d    = S_RUN;
            wait_clr_s = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (mem_req_Mem && !mem_ack) begin
                        ctrl_s     = CTRL_FREEZE;
                        wait_inc_s = 1'b1;
                        state_d    = S_MEM_WAIT;
                    end else if (hazard_stall) begin
                        ctrl_s = CTRL_HAZARD;
                    end else if (branch_taken_ID || jump_ID) begin
                        ctrl_s = CTRL_FLUSH;
                    end else begin
                        ctrl_s = CTRL_RUN;
                    end
                end
                S_MEM_WAIT: begin
                    // mem_req_Mem dropping here is illegal and treated as waiting.
                    if (mem_ack) begin
                        ctrl_s     = CTRL_RUN;
                        wait_clr_s = 1'b1;
                        state_d    = S_RUN;
                    end else if (wait_cnt_s == TIMEOUT_LAST) begin
                        ctrl_s     = CTRL_FREEZE;
                        wait_inc_s = 1'b1;
                        err_set_s  = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        ctrl_s     = CTRL_FREEZE;
                        wait_inc_s = 1'b1;
                        state_d    = S_MEM_WAIT;
                    end
                end
                S_HALT: begin
                    ctrl_s     = CTRL_NONE;
                    wait_clr_s = 1'b1;
                    state_d    = S_HALT;
                end
                default: begin
                    ctrl_s     = CTRL_NONE;
                    wait_clr_s = 1'b1;
                    state_d    = S_RUN;
                end
            endcase
        end
    end

    // State and sticky timeout error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_q | err_set_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .clr_i (wait_clr_s),
        .inc_i (wait_inc_s),
        .cnt_o (wait_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (!ctrl_s.pc_wr),
        .cnt_o (stall_cnt)
    );

    assign PC_Wr        = ctrl_s.pc_wr;
    assign IFID_Wr      = ctrl_s.ifid_wr;
    assign IDEx_Wr      = ctrl_s.idex_wr;
    assign ExMem_Wr     = ctrl_s.exmem_wr;
    assign MemWb_Wr     = ctrl_s.memwb_wr;
    assign IFID_flush   = ctrl_s.ifid_flush;
    assign IDEx_bubble  = ctrl_s.idex_bubble;
    assign MemWb_bubble = ctrl_s.memwb_bubble;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: stimulus pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;

    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_RUN  = 8'b1111_1000;
    localparam logic [7:0] E_FLSH = 8'b1111_1100;
    localparam logic [7:0] E_HAZ  = 8'b0011_1010;
    localparam logic [7:0] E_FRZ  = 8'b0000_1001;

    typedef struct {
        logic [7:0] ctrl;
        logic       err;
        logic [3:0] cnt;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hazard_stall = 1'b0;
    logic       branch_taken_ID = 1'b0;
    logic       jump_ID = 1'b0;
    logic       mem_req_Mem = 1'b0;
    logic       mem_ack = 1'b0;
    logic       PC_Wr, IFID_Wr, IDEx_Wr, ExMem_Wr, MemWb_Wr;
    logic       IFID_flush, IDEx_bubble, MemWb_bubble, mem_err;
    logic [3:0] stall_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_stall    (hazard_stall),
        .branch_taken_ID (branch_taken_ID),
        .jump_ID         (jump_ID),
        .mem_req_Mem     (mem_req_Mem),
        .mem_ack         (mem_ack),
        .PC_Wr           (PC_Wr),
        .IFID_Wr         (IFID_Wr),
        .IDEx_Wr         (IDEx_Wr),
        .ExMem_Wr        (ExMem_Wr),
        .MemWb_Wr        (MemWb_Wr),
        .IFID_flush      (IFID_flush),
        .IDEx_bubble     (IDEx_bubble),
        .MemWb_bubble    (MemWb_bubble),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue its expected outputs.
    task automatic step(input logic r, input logic hz, input logic br, input logic jp,
                        input logic mr, input logic ak, input logic [7:0] ec,
                        input logic ee, input logic [3:0] ecnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hazard_stall = hz; branch_taken_ID = br; jump_ID = jp;
        mem_req_Mem = mr; mem_ack = ak;
        e.ctrl = ec; e.err = ee; e.cnt = ecnt; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {PC_Wr, IFID_Wr, IDEx_Wr, ExMem_Wr, MemWb_Wr,
                   IFID_flush, IDEx_bubble, MemWb_bubble};
            checks++;
            if (act === e.ctrl && mem_err === e.err && stall_cnt === e.cnt) begin
                passes++;
            end else begin
                $display("FAIL %s: ctrl=%b err=%b cnt=%0d, want ctrl=%b err=%b cnt=%0d",
                         e.name, act, mem_err, stall_cnt, e.ctrl, e.err, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, 1'b0, 4'd0, "reset");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, 1'b0, 4'd0, "reset2");
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, 1'b0, 4'd0, "idle");

        // Load-use with a simultaneous taken branch: flush suppressed.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_HAZ,  1'b0, 4'd0, "hz_br");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_FLSH, 1'b0, 4'd1, "br_after");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_FLSH, 1'b0, 4'd1, "jump");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_HAZ,  1'b0, 4'd1, "hz_only");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,  1'b0, 4'd2, "idle_cnt2");

        // Memory wait of three cycles; ID requests and req drop ignored while waiting.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, 1'b0, 4'd2, "rst_mw");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd0, "mw1");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd1, "mw2_ign");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_FRZ,  1'b0, 4'd2, "mw3_nreq");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN,  1'b0, 4'd3, "mw_ack");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,  1'b0, 4'd3, "mw_back");

        // Single-cycle accesses.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN,  1'b0, 4'd3, "single");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_HAZ,  1'b0, 4'd3, "single_hz");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,  1'b0, 4'd4, "single_end");

        // Timeout into HALT; ack in HALT does not release it; counter saturates.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, 1'b0, 4'd4, "rst_to");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd0, "to1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd1, "to2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd2, "to3");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd3, "to4");
        for (int k = 0; k < 20; k++) begin
            c = (4 + k > 15) ? 15 : 4 + k;
            step(1'b0, k[0], 1'b0, 1'b0, 1'b1, 1'b1, E_NONE, 1'b1, 4'(c), "halt");
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, 1'b1, 4'd15, "rst_halt");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,  1'b0, 4'd0, "after_halt");

        // Ack on the would-be timeout cycle wins.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd0, "ta1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd1, "ta2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd2, "ta3");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN,  1'b0, 4'd3, "ta_ack");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,  1'b0, 4'd3, "ta_run");

        // Reset mid-wait leaves no residual freeze or wait count.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd3, "rm1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_NONE, 1'b0, 4'd4, "rm_rst");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,  1'b0, 4'd0, "rm_run");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd0, "rw1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd1, "rw2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ,  1'b0, 4'd2, "rw3");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN,  1'b0, 4'd3, "rw_ack");

        // Saturation under 20 hazard stalls.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, 1'b0, 4'd3, "rst_sat");
        for (int k = 0; k < 20; k++) begin
            c = (k > 15) ? 15 : k;
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_HAZ, 1'b0, 4'(c), "sat");
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN,  1'b0, 4'd15, "sat_hold");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
